// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response and the decode handshake.
// master = fetch unit side, slave = memory/decode side.
interface instruction_fetch_unit_if;
    logic        iMemRead;
    logic [31:0] iMemAddr;
    logic        iMemGrant;
    logic        iMemValid;
    logic [31:0] iMemRdata;
    logic        instrValid;
    logic [31:0] instruction;
    logic [31:0] instrPc;
    logic        instrReady;

    modport master (
        output iMemRead, iMemAddr, instrValid, instruction, instrPc,
        input  iMemGrant, iMemValid, iMemRdata, instrReady
    );

    modport slave (
        input  iMemRead, iMemAddr, instrValid, instruction, instrPc,
        output iMemGrant, iMemValid, iMemRdata, instrReady
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: PC, single-outstanding instruction-memory reads, small FIFO to decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect raises sticky fetchFault and halts.
//
// state  | meaning
// IDLE   | just out of reset, one cycle before the first request
// REQ    | request pc when buffer has room, wait for grant
// WAIT   | one read outstanding, wait for its response
// HALTED | no further fetching, buffer drains, left only by reset
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    instruction_fetch_unit_if.master        bus,
    input  logic                            redirectValid,
    input  logic [31:0]                     redirectPc,
    input  logic                            halt,
    output logic [1:0]                      fetchState,
    output logic                            fetchFault
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic              drop_q, drop_d;
    logic              halt_seen_q, halt_seen_d;
    logic              fault_q, fault_d;
    logic              rd_q, rd_d;
    logic [31:0]       addr_q, addr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [31:0]       buf_data_q [BUF_DEPTH];
    logic [31:0]       buf_data_d [BUF_DEPTH];
    logic [31:0]       buf_pc_q   [BUF_DEPTH];
    logic [31:0]       buf_pc_d   [BUF_DEPTH];

    logic              grant;
    logic              push;
    logic              pop;
    logic              flush;
    logic              misaligned;
    logic [31:0]       redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = (redirectPc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    assign redirect_target = redirectPc & ~32'h3;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        drop_d      = drop_q;
        halt_seen_d = halt_seen_q | halt;
        fault_d     = fault_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_data_d  = buf_data_q;
        buf_pc_d    = buf_pc_q;
        grant       = rd_q & bus.iMemGrant;
        pop         = (count_q != '0) & bus.instrReady;
        push        = 1'b0;
        flush       = 1'b0;

        case (state_q)
            IDLE: state_d = halt_seen_d ? HALTED : REQ;
            REQ: begin
                if (grant) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = WAIT;
                end else if (halt_seen_d) begin
                    state_d = HALTED;
                end
            end
            WAIT: begin
                if (bus.iMemValid) begin
                    push    = ~drop_q;
                    drop_d  = 1'b0;
                    state_d = halt_seen_d ? HALTED : REQ;
                end
            end
            default: ;
        endcase

        // Redirect overrides any push/pop decided above; the in-flight read becomes stale.
        if (redirectValid && state_q != HALTED) begin
            flush = 1'b1;
            push  = 1'b0;
            if (misaligned) begin
                fault_d = 1'b1;
                state_d = HALTED;
            end else begin
                pc_d = redirect_target;
                if ((state_q == REQ && grant) || (state_q == WAIT && !bus.iMemValid))
                    drop_d = 1'b1;
            end
        end

        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                buf_data_d[wr_ptr_q] = bus.iMemRdata;
                buf_pc_d[wr_ptr_q]   = req_pc_q;
                wr_ptr_d             = wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: ;
            endcase
        end

        rd_d   = (state_d == REQ) && (count_d < DEPTH_C) && !halt_seen_d;
        addr_d = pc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            drop_q      <= 1'b0;
            halt_seen_q <= 1'b0;
            fault_q     <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            buf_data_q  <= '{default: '0};
            buf_pc_q    <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            drop_q      <= drop_d;
            halt_seen_q <= halt_seen_d;
            fault_q     <= fault_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_data_q  <= buf_data_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign bus.iMemRead    = rd_q;
    assign bus.iMemAddr    = addr_q;
    assign bus.instrValid  = (count_q != '0);
    assign bus.instruction = buf_data_q[rd_ptr_q];
    assign bus.instrPc     = buf_pc_q[rd_ptr_q];
    assign fetchState      = state_q;
    assign fetchFault      = fault_q;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the multi-cycle RV32I core: owns the program counter, issues single-outstanding reads to instruction memory, and buffers returned words in a small FIFO that feeds decode through a valid/ready handshake. It sits between the instruction memory port and the decode/control FSM inside `processorWrapper`. Control-flow redirects from execute (branch, jal, jalr) flush the buffer and discard stale in-flight data.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `BUF_DEPTH`, 2, instruction buffer entries (power of two, 2..8)
- `clk` in 1 clock, all state on rising edge
- `rst` in 1 reset, asynchronous, active-low
- `iMemRead` out 1 read request, held high until accepted
- `iMemAddr` out 32 word-aligned request address
- `iMemGrant` in 1 memory accepts request this cycle
- `iMemValid` in 1 read data valid (exactly one per granted request)
- `iMemRdata` in 32 read data
- `instrValid` out 1 buffer head valid
- `instruction` out 32 buffer head word
- `instrPc` out 32 PC of buffer head
- `instrReady` in 1 decode consumes head this cycle
- `redirectValid` in 1 redirect request from execute
- `redirectPc` in 32 redirect target
- `halt` in 1 stop fetching (sticky until reset)
- `fetchState` out 2 FSM state (debug)
- `fetchFault` out 1 misaligned redirect flagged (see Configuration)

## Operation
- FSM states: IDLE=0, REQ=1, WAIT=2, HALTED=3.
- IDLE: entered from reset; next cycle -> REQ.
- REQ: `iMemRead`=1, `iMemAddr`=pc. Request only asserted when buffer count + outstanding < BUF_DEPTH, otherwise stay in REQ with `iMemRead`=0. On `iMemGrant`: pc <= pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000), record request PC, -> WAIT.
- WAIT: on `iMemValid`, push {`iMemRdata`, request PC} unless the response is stale; -> REQ (or HALTED if halt seen).
- Stale tracking: one `dropNext` flag. Redirect while in WAIT (or in REQ on the grant cycle) sets `dropNext`; the matching response is discarded and clears it.
- Redirect (any state except HALTED): pc <= `redirectPc`, buffer flushed (count=0, `instrValid`=0 next cycle), FSM -> REQ once no response is outstanding. Redirect wins over a same-cycle push and pop.
- Halt: sampled every cycle; no new grant requested after halt; outstanding response still accepted and buffered; -> HALTED. HALTED: `iMemRead`=0, buffer still drains to decode, exits only via reset.
- Buffer: FIFO, simultaneous push and pop when full is legal (count unchanged). Pop occurs when `instrValid` & `instrReady`.

## Timing
- Reset values: pc=RESET_PC, `iMemRead`=0, `iMemAddr`=0, `instrValid`=0, `instruction`=0, `instrPc`=0, `fetchState`=IDLE, `fetchFault`=0, buffer empty, `dropNext`=0.
- First `iMemRead` in the 2nd rising edge after `rst` deasserts.
- Minimum fetch-to-decode latency: grant at cycle N, `iMemValid` at N+1, `instrValid` at N+2 (registered buffer output).
- Throughput with 1-cycle memory: one instruction per 2 cycles (single outstanding).
- `iMemAddr`/`iMemRead` stable while waiting for grant; redirect during un-granted REQ updates `iMemAddr` next cycle.
- Reset mid-operation: all state cleared immediately; a response arriving after reset with no request is ignored.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: redirect with `redirectPc[1:0]`!=0 sets `fetchFault` (sticky), flushes buffer, FSM -> HALTED, no fetch issued.
- Not defined: `redirectPc[1:0]` forced to 0, redirect proceeds normally, `fetchFault` tied 0.

## Test plan
- Reset release, memory returns `0x00500093` at addr 0, 1-cycle latency -> `instrValid` with `instruction`=0x00500093, `instrPc`=0; next `iMemAddr`=4.
- `instrReady`=0 for 10 cycles -> exactly BUF_DEPTH (2) grants, then `iMemRead` stays 0; raising `instrReady` pops PC 0,4 in order.
- Redirect to 0x100 while in WAIT for addr 8 -> addr-8 data discarded, next `iMemAddr`=0x100, first decoded `instrPc`=0x100.
- Redirect same cycle as `iMemValid` and `instrReady` with full buffer -> buffer empty next cycle, no stale word ever visible.
- `halt` asserted in WAIT -> pending word buffered and drained, `fetchState`=3, `iMemRead` never reasserts.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x102 -> `fetchFault`=1, HALTED; without: fetch proceeds at 0x100.
